configregpwm_decode: RTL

CONFIGREGPWM_DECODE -- requirements
Module: configregpwm_decode

---
 rtl/configregpwm_decode.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/configregpwm_decode.sv
// PWM config register decoder with period-synchronised shadow transfer.
// Optional CONFIGREGPWM_READBACK_EN adds reg_active readback of active fields.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module configregpwm_decode #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`PWMCOUNT_WIDTH-1:0] reg_in,
    input  logic                       reg_wr,
    input  logic                       period_sync,
    input  logic                       err_clr,
    output logic                       pwm_onoff,
    output logic                       int_onoff,
    output logic                       pwmclkdiv_onoff,
    output logic                       dtclkdiv_onoff,
    output logic                       mask_mode,
    output logic [1:0]                 count_mode,
`ifdef CONFIGREGPWM_READBACK_EN
    output logic [`PWMCOUNT_WIDTH-1:0] reg_active,
`endif
    output logic                       update_pulse,
    output logic                       pending,
    output logic                       cfg_err
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    act_q, act_d;
    logic [6:0]    shd_q, shd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_q, upd_d;
    logic          err_q, err_d;

    logic [6:0] dec;
    logic       illegal;
    logic       legal;
    logic       expire;
    logic       unused_hi;

    assign dec       = reg_in[6:0];
    assign unused_hi = ^reg_in[`PWMCOUNT_WIDTH-1:7];
    assign illegal   = reg_wr && (reg_in[1:0] == 2'b11);
    assign legal     = reg_wr && !illegal;

    generate
        if (TIMEOUT > 0) begin : g_tmo
            assign expire = (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        shd_d   = shd_q;
        cnt_d   = '0;
        upd_d   = 1'b0;
        err_d   = illegal | (err_q & ~err_clr);
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    if (!act_q[6]) begin
                        act_d = dec;
                        upd_d = 1'b1;
                    end else begin
                        shd_d   = dec;
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A coincident write re-arms the shadow after the old value lands
                if (period_sync || expire) begin
                    act_d = shd_q;
                    upd_d = 1'b1;
                    cnt_d = '0;
                    if (legal) begin
                        shd_d = dec;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (legal) begin
                    shd_d = dec;
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= '0;
            shd_q   <= '0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign pwm_onoff       = act_q[6];
    assign int_onoff       = act_q[5];
    assign pwmclkdiv_onoff = act_q[4];
    assign dtclkdiv_onoff  = act_q[3];
    assign mask_mode       = act_q[2];
    assign count_mode      = act_q[1:0];
    assign update_pulse    = upd_q;
    assign pending         = (state_q == PENDING);
    assign cfg_err         = err_q;

`ifdef CONFIGREGPWM_READBACK_EN
    always_comb begin
        reg_active      = '0;
        reg_active[6:0] = act_q;
    end
`endif

endmodule
